// File: rtl/packed_table_streamer.sv
// Streams a constant, compile-time table of packed entries over a valid/ready
// port and accumulates an XOR checksum of every word the consumer accepted.
module packed_table_streamer #(
  parameter int WORD_W      = 32,
  parameter int NUM_WORDS   = 3,
  parameter int NUM_ENTRIES = 3,
  parameter int LOOP        = 0,
  localparam int IW         = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
  localparam int DATA_W     = NUM_WORDS * WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IW-1:0]     out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ENTRIES - 1);

  state_t            state;
  logic [IW-1:0]     index;
  logic [WORD_W-1:0] csum;
  logic              stop_pending;

  logic              xfer;
  logic              is_last;
  logic              finish;
  logic [3:0]        tag_nib;
  logic [WORD_W-1:0] tag_word;
  logic [DATA_W-1:0] entry_data;
  logic [WORD_W-1:0] entry_xor;

  // Entry e carries tag (e+1) mod 16 in the top nibble of every word.
  assign tag_nib  = 4'(int'(index) + 1);
  assign tag_word = {tag_nib, {(WORD_W-4){1'b0}}};

  always_comb begin
    entry_data = '0;
    entry_xor  = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      entry_data[w*WORD_W +: WORD_W] = tag_word | WORD_W'(w);
      entry_xor                      = entry_xor ^ (tag_word | WORD_W'(w));
    end
  end

  assign is_last = (index == LAST_IDX);
  assign xfer    = (state == SEND) && out_ready;
  // A looping stream ends on the first transfer at or after a stop request;
  // a one-shot stream ends on its last entry and never looks at stop.
  assign finish  = (LOOP != 0) ? (stop_pending || stop) : is_last;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      index        <= '0;
      csum         <= '0;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= SEND;
            index        <= '0;
            csum         <= '0;
            stop_pending <= 1'b0;
          end
        end
        SEND: begin
          if ((LOOP != 0) && stop) stop_pending <= 1'b1;
          if (xfer) begin
            csum <= csum ^ entry_xor;
            if (finish) state <= DONE;
            else        index <= is_last ? '0 : index + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == SEND);
  assign done      = (state == DONE);
  assign out_valid = busy;
  assign out_data  = entry_data;
  assign out_index = index;
  assign out_last  = is_last;
  assign checksum  = csum;

endmodule

// File: tb/tb_packed_table_streamer.sv
// Directed bench for packed_table_streamer: one-shot, looping and single-entry
// configurations run side by side on a shared clock and reset.
module tb_packed_table_streamer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Defaults, one-shot
  logic        start0, stop0, ready0, valid0, last0, busy0, done0;
  logic [95:0] data0;
  logic [1:0]  idx0;
  logic [31:0] csum0;
  // Defaults, looping
  logic        start1, stop1, ready1, valid1, last1, busy1, done1;
  logic [95:0] data1;
  logic [1:0]  idx1;
  logic [31:0] csum1;
  // Single entry, single 8-bit word
  logic        start2, stop2, ready2, valid2, last2, busy2, done2;
  logic [7:0]  data2;
  logic [0:0]  idx2;
  logic [7:0]  csum2;

  logic [95:0] exp_data [3];

  packed_table_streamer u0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .out_valid(valid0),
    .out_ready(ready0), .out_data(data0), .out_index(idx0), .out_last(last0),
    .busy(busy0), .done(done0), .checksum(csum0));

  packed_table_streamer #(.LOOP(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .out_valid(valid1),
    .out_ready(ready1), .out_data(data1), .out_index(idx1), .out_last(last1),
    .busy(busy1), .done(done1), .checksum(csum1));

  packed_table_streamer #(.WORD_W(8), .NUM_WORDS(1), .NUM_ENTRIES(1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .out_valid(valid2),
    .out_ready(ready2), .out_data(data2), .out_index(idx2), .out_last(last2),
    .busy(busy2), .done(done2), .checksum(csum2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    tick(); tick();
    total++; if ({valid0, busy0, done0, idx0, csum0} !== {3'b000, 2'd0, 32'd0}) begin
      bad++; $display("FAIL reset_u0 got=%h want=%h", {valid0, busy0, done0, idx0, csum0}, {3'b000, 2'd0, 32'd0}); end
    total++; if ({valid1, busy1, done1, idx1, csum1} !== {3'b000, 2'd0, 32'd0}) begin
      bad++; $display("FAIL reset_u1 got=%h want=%h", {valid1, busy1, done1, idx1, csum1}, {3'b000, 2'd0, 32'd0}); end
    total++; if ({valid2, busy2, done2, idx2, csum2} !== {3'b000, 1'b0, 8'd0}) begin
      bad++; $display("FAIL reset_u2 got=%h want=%h", {valid2, busy2, done2, idx2, csum2}, {3'b000, 1'b0, 8'd0}); end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
    tick();
    total++; if ({busy0, done0} !== 2'b00) begin
      bad++; $display("FAIL idle_hold got=%b want=00", {busy0, done0}); end
  endtask

  // One-shot stream; stop is held during the first beat and must be ignored.
  task automatic test_stream;
    ready0 = 1'b1; start0 = 1'b1; stop0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int b = 0; b < 3; b++) begin
      total++; if ({valid0, busy0, idx0, last0} !== {2'b11, 2'(b), (b == 2)}) begin
        bad++; $display("FAIL stream_ctl b=%0d got=%b want=%b", b, {valid0, busy0, idx0, last0}, {2'b11, 2'(b), (b == 2)}); end
      total++; if (data0 !== exp_data[b]) begin
        bad++; $display("FAIL stream_data b=%0d got=%h want=%h", b, data0, exp_data[b]); end
      tick();
      stop0 = 1'b0;
    end
    total++; if ({done0, busy0, valid0, csum0} !== {3'b100, 32'h0000_0003}) begin
      bad++; $display("FAIL stream_done got=%h want=%h", {done0, busy0, valid0, csum0}, {3'b100, 32'h0000_0003}); end
    tick();
    total++; if ({done0, csum0} !== {1'b1, 32'h0000_0003}) begin
      bad++; $display("FAIL done_hold got=%h want=%h", {done0, csum0}, {1'b1, 32'h0000_0003}); end
  endtask

  // Consumer stalls four cycles while entry 1 is presented.
  task automatic test_backpressure;
    int xfers = 0;
    int stalls = 0;
    ready0 = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int c = 0; c < 20 && !done0; c++) begin
      if (busy0 && idx0 == 2'd1 && stalls < 4) begin
        ready0 = 1'b0;
        stalls++;
        total++; if ({valid0, idx0, data0} !== {1'b1, 2'd1, exp_data[1]}) begin
          bad++; $display("FAIL stall_hold c=%0d got=%h want=%h", c, {valid0, idx0, data0}, {1'b1, 2'd1, exp_data[1]}); end
      end else begin
        ready0 = 1'b1;
      end
      if (valid0 && ready0) xfers++;
      tick();
    end
    total++; if (xfers !== 3) begin
      bad++; $display("FAIL bp_xfers got=%0d want=3", xfers); end
    total++; if ({done0, csum0} !== {1'b1, 32'h0000_0003}) begin
      bad++; $display("FAIL bp_done got=%h want=%h", {done0, csum0}, {1'b1, 32'h0000_0003}); end
  endtask

  // Looping stream, stop during beat 4 (index 1). Entry XORs are
  // 1000_0003, 2000_0003, 3000_0003; over e0,e1,e2,e0,e1 that folds to 3000_0003.
  task automatic test_loop_stop;
    ready1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int b = 0; b < 5; b++) begin
      total++; if ({valid1, idx1, data1} !== {1'b1, 2'(b % 3), exp_data[b % 3]}) begin
        bad++; $display("FAIL loop_beat b=%0d got=%h want=%h", b, {valid1, idx1, data1}, {1'b1, 2'(b % 3), exp_data[b % 3]}); end
      if (b == 4) stop1 = 1'b1;
      tick();
      stop1 = 1'b0;
    end
    total++; if ({done1, busy1, csum1} !== {2'b10, 32'h3000_0003}) begin
      bad++; $display("FAIL loop_done got=%h want=%h", {done1, busy1, csum1}, {2'b10, 32'h3000_0003}); end
  endtask

  // Stop arrives while stalled; the stream must end on the next transfer.
  task automatic test_stop_pending;
    ready1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0; stop1 = 1'b1;
    tick();
    stop1 = 1'b0;
    tick();
    total++; if ({busy1, idx1, done1} !== {1'b1, 2'd0, 1'b0}) begin
      bad++; $display("FAIL pend_wait got=%b want=%b", {busy1, idx1, done1}, {1'b1, 2'd0, 1'b0}); end
    ready1 = 1'b1;
    tick();
    total++; if ({done1, busy1, csum1} !== {2'b10, 32'h1000_0003}) begin
      bad++; $display("FAIL pend_done got=%h want=%h", {done1, busy1, csum1}, {2'b10, 32'h1000_0003}); end
    ready1 = 1'b0;
  endtask

  task automatic test_reset_midstream;
    ready0 = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    total++; if ({valid0, idx0} !== {1'b1, 2'd1}) begin
      bad++; $display("FAIL mid_pre got=%b want=%b", {valid0, idx0}, {1'b1, 2'd1}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({valid0, busy0, done0, idx0, csum0} !== {3'b000, 2'd0, 32'd0}) begin
      bad++; $display("FAIL mid_rst got=%h want=%h", {valid0, busy0, done0, idx0, csum0}, {3'b000, 2'd0, 32'd0}); end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    total++; if ({valid0, idx0, csum0} !== {1'b1, 2'd0, 32'd0}) begin
      bad++; $display("FAIL mid_restart got=%h want=%h", {valid0, idx0, csum0}, {1'b1, 2'd0, 32'd0}); end
    tick();
    total++; if (csum0 !== 32'h1000_0003) begin
      bad++; $display("FAIL mid_csum got=%h want=10000003", csum0); end
    tick(); tick();
    total++; if ({done0, csum0} !== {1'b1, 32'h0000_0003}) begin
      bad++; $display("FAIL mid_done got=%h want=%h", {done0, csum0}, {1'b1, 32'h0000_0003}); end
  endtask

  task automatic test_start_held;
    ready0 = 1'b1; start0 = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      total++; if ({busy0, idx0} !== {1'b1, 2'(b)}) begin
        bad++; $display("FAIL held_beat b=%0d got=%b want=%b", b, {busy0, idx0}, {1'b1, 2'(b)}); end
      tick();
    end
    total++; if ({done0, csum0} !== {1'b1, 32'h0000_0003}) begin
      bad++; $display("FAIL held_done got=%h want=%h", {done0, csum0}, {1'b1, 32'h0000_0003}); end
    tick();
    total++; if ({busy0, idx0, csum0} !== {1'b1, 2'd0, 32'd0}) begin
      bad++; $display("FAIL held_retrig got=%h want=%h", {busy0, idx0, csum0}, {1'b1, 2'd0, 32'd0}); end
    start0 = 1'b0;
    tick(); tick(); tick();
    total++; if (done0 !== 1'b1) begin
      bad++; $display("FAIL held_drain got=%b want=1", done0); end
  endtask

  task automatic test_single;
    ready2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    total++; if ({valid2, last2, idx2, data2} !== {3'b110, 8'h10}) begin
      bad++; $display("FAIL single_beat got=%h want=%h", {valid2, last2, idx2, data2}, {3'b110, 8'h10}); end
    tick();
    total++; if ({done2, busy2, idx2, csum2} !== {3'b100, 8'h10}) begin
      bad++; $display("FAIL single_done got=%h want=%h", {done2, busy2, idx2, csum2}, {3'b100, 8'h10}); end
  endtask

  initial begin
    exp_data[0] = 96'h10000002_10000001_10000000;
    exp_data[1] = 96'h20000002_20000001_20000000;
    exp_data[2] = 96'h30000002_30000001_30000000;
    rst = 1'b1;
    start0 = 1'b0; stop0 = 1'b0; ready0 = 1'b0;
    start1 = 1'b0; stop1 = 1'b0; ready1 = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; ready2 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_loop_stop();
    test_stop_pending();
    test_reset_midstream();
    test_start_held();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
